// File: rtl/pp_pkg.sv
// Shared types and constants for the preprocess mode controller.
package pp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_DRAIN      = 3'd2,
    ST_FLUSH      = 3'd3,
    ST_APPLY      = 3'd4
  } pp_state_t;

  localparam logic PP_MODE_PASS = 1'b0;
  localparam logic PP_MODE_GREY = 1'b1;

  localparam int PP_CNT_W   = 12;
  localparam int PP_FLUSH_W = 4;

endpackage

// File: rtl/pp_mode_ctrl.sv
// Frame-aligned mode switch for the preprocess block: waits for vsync,
// drains the output buffer, flushes, then applies the new mode.
module pp_mode_ctrl
  import pp_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 4095,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mode_req,
  input  logic        i_mode_req_valid,
  input  logic        i_vsync,
  input  logic        i_almostempty,
  input  logic [10:0] i_out_fill,
  output logic        o_almostempty,
  output logic        o_flush,
  output logic        o_mode,
  output logic        o_mode_ack,
  output logic        o_busy,
  output logic        o_drain_err
);

  localparam int TIMEOUT_CLAMP = (DRAIN_TIMEOUT > 4095) ? 4095 : DRAIN_TIMEOUT;
  localparam logic [PP_CNT_W-1:0]   TIMEOUT_LIM = PP_CNT_W'(TIMEOUT_CLAMP);
  localparam logic [PP_FLUSH_W-1:0] FLUSH_LAST  = PP_FLUSH_W'(FLUSH_CYCLES - 1);

  pp_state_t             state_reg, state_next;
  logic                  pend_valid_reg, pend_valid_next;
  logic                  pend_mode_reg, pend_mode_next;
  logic                  mode_reg, mode_next;
  logic                  ack_reg, ack_next;
  logic                  drain_err_reg, drain_err_next;
  logic [PP_CNT_W-1:0]   cnt_reg, cnt_next;
  logic [PP_FLUSH_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic                  req_valid;
  logic                  req_mode;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      pend_valid_reg <= 1'b0;
      pend_mode_reg  <= PP_MODE_PASS;
      mode_reg       <= PP_MODE_PASS;
      ack_reg        <= 1'b0;
      drain_err_reg  <= 1'b0;
      cnt_reg        <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_valid_next;
      pend_mode_reg  <= pend_mode_next;
      mode_reg       <= mode_next;
      ack_reg        <= ack_next;
      drain_err_reg  <= drain_err_next;
      cnt_reg        <= cnt_next;
      flush_cnt_reg  <= flush_cnt_next;
    end
  end

  always_comb begin
    // IDLE sees a same-cycle request directly so an already-applied mode acks next cycle
    req_valid       = i_mode_req_valid | pend_valid_reg;
    req_mode        = i_mode_req_valid ? i_mode_req : pend_mode_reg;
    state_next      = state_reg;
    pend_valid_next = pend_valid_reg | i_mode_req_valid;
    pend_mode_next  = req_mode;
    mode_next       = mode_reg;
    ack_next        = 1'b0;
    drain_err_next  = drain_err_reg;
    cnt_next        = cnt_reg;
    flush_cnt_next  = flush_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          pend_valid_next = 1'b0;
          if (req_mode == mode_reg) begin
            ack_next = 1'b1;
          end else begin
            state_next = ST_WAIT_FRAME;
          end
        end
      end
      ST_WAIT_FRAME: begin
        if (i_vsync) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
        end
      end
      ST_DRAIN: begin
        if (i_out_fill == '0) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = '0;
        end else if (cnt_reg >= TIMEOUT_LIM) begin
          drain_err_next = 1'b1;
          state_next     = ST_FLUSH;
          flush_cnt_next = '0;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_reg == FLUSH_LAST) begin
          state_next     = ST_APPLY;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt_reg + 1'b1;
        end
      end
      ST_APPLY: begin
        // Newest request wins; one arriving later stays pending for IDLE
        mode_next  = pend_mode_reg;
        ack_next   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_almostempty = ((state_reg == ST_DRAIN) || (state_reg == ST_FLUSH) ||
                          (state_reg == ST_APPLY)) ? 1'b1 : i_almostempty;
  assign o_flush       = (state_reg == ST_FLUSH);
  assign o_mode        = mode_reg;
  assign o_mode_ack    = ack_reg;
  assign o_busy        = (state_reg != ST_IDLE);
  assign o_drain_err   = drain_err_reg;

endmodule

// File: doc/pp_mode_ctrl.md
PP_MODE_CTRL -- requirements
Module: pp_mode_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 4095, max cycles to wait for output buffer drain.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, width of flush pulse in cycles (1..15).
REQ-003 SHALL have port i_clk  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port i_rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port i_mode_req  in  1  requested mode (0 passthrough, 1 greyscale).
REQ-006 SHALL have port i_mode_req_valid  in  1  single-cycle request strobe.
REQ-007 SHALL have port i_vsync  in  1  single-cycle frame-start pulse.
REQ-008 SHALL have port i_almostempty  in  1  upstream input-FIFO almost-empty.
REQ-009 SHALL have port i_out_fill  in  11  preprocess output-buffer fill count.
REQ-010 SHALL have port o_almostempty  out  1  gated almost-empty to preprocess.
REQ-011 SHALL have port o_flush  out  1  flush to preprocess.
REQ-012 SHALL have port o_mode  out  1  applied mode to preprocess.
REQ-013 SHALL have port o_mode_ack  out  1  single-cycle pulse when a request completes.
REQ-014 SHALL have port o_busy  out  1  high in any state except IDLE.
REQ-015 SHALL have port o_drain_err  out  1  sticky drain-timeout flag.

Function
REQ-016 SHALL implement states IDLE, WAIT_FRAME, DRAIN, FLUSH, APPLY.
REQ-017 SHALL latch i_mode_req into a pending register on every i_mode_req_valid, in any state; newest request wins.
REQ-018 IDLE: on a pending request equal to o_mode, SHALL clear pending and pulse o_mode_ack next cycle without leaving IDLE.
REQ-019 IDLE: on a pending request differing from o_mode, SHALL go to WAIT_FRAME; an i_vsync coincident with the request cycle SHALL NOT count.
REQ-020 WAIT_FRAME: on i_vsync SHALL go to DRAIN and clear the timeout counter.
REQ-021 In DRAIN, FLUSH and APPLY, o_almostempty SHALL be 1; otherwise o_almostempty SHALL equal i_almostempty (combinational).
REQ-022 DRAIN: when i_out_fill==0 SHALL go to FLUSH; when counter reaches DRAIN_TIMEOUT SHALL set o_drain_err and go to FLUSH.
REQ-023 FLUSH: o_flush SHALL be high exactly FLUSH_CYCLES consecutive cycles, then go to APPLY.
REQ-024 APPLY: SHALL load o_mode from pending, pulse o_mode_ack for one cycle, go to IDLE.
REQ-025 A request arriving in DRAIN/FLUSH/APPLY SHALL be kept pending and serviced from IDLE after the current sequence.
REQ-026 Total latency vsync->ack with empty buffer SHALL be 2+FLUSH_CYCLES+1 cycles.
REQ-027 Timeout counter SHALL be 12 bits wide, saturating, never wrapping.
REQ-028 o_mode SHALL change only in APPLY.

Reset
REQ-029 On i_rst: state IDLE, o_mode 0, o_flush 0, o_mode_ack 0, o_busy 0, o_drain_err 0, pending cleared, counters 0.
REQ-030 Reset asserted mid-sequence SHALL abort immediately, with no ack issued and mode reverting to 0.
REQ-031 o_drain_err SHALL clear only on reset.

Structure
REQ-032 Shared package pp_pkg SHALL hold the state enum and constants PP_MODE_PASS=0 and PP_MODE_GREY=1.
REQ-033 Counters and FSM SHALL be inline; no sub-module.

Verification
REQ-034 Request 1 while o_mode=0, vsync 5 cycles later, fill=0 -> o_flush high 2 cycles, o_mode=1, ack 5 cycles after vsync.
REQ-035 Request 0 while o_mode=0 -> ack next cycle, o_flush never asserted, o_busy stays 0.
REQ-036 Fill held at 100 through DRAIN -> o_drain_err=1 at 4095 cycles, flush follows, mode applied.
REQ-037 Requests 1 then 0 during DRAIN with o_mode=0 -> first sequence acks with mode 0, then immediate ack, final o_mode=0.
REQ-038 i_rst asserted during FLUSH -> o_flush=0, o_mode=0, no ack, state IDLE.
REQ-039 i_almostempty=0 during DRAIN -> o_almostempty=1; in IDLE -> o_almostempty follows input.
